// File: rtl/ram_iir_allpole_pkg.sv
// Shared types and helpers for the RAM-based all-pole IIR filter.
// Optional saturation of the result is enabled with the IIR_SAT_EN macro.
package iir_pkg;

  typedef enum logic [2:0] {
    CLEAR_S,
    IDLE_S,
    RUN_S,
    LAST_S,
    WRITE_S
  } state_e;

  // Accumulator width: product after the shift needs DW+1 bits, plus growth over ORDER taps.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned order);
    return dw + 2 + $clog2(order);
  endfunction

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int unsigned     dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ram_iir_allpole_if.sv
// Sample-in / result-out handshake of the all-pole IIR filter.
// Signal names keep the filter's point of view: _i into the filter, _o out of it.
interface ram_iir_allpole_if #(
  parameter int unsigned DW = 16
) ();

  logic          sample_valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          data_valid_o;

  // Sample source side.
  modport master (
    output sample_valid_i,
    output data_i,
    input  ready_o,
    input  data_o,
    input  data_valid_o
  );

  // Filter side.
  modport slave (
    input  sample_valid_i,
    input  data_i,
    output ready_o,
    output data_o,
    output data_valid_o
  );

endinterface

// File: rtl/iir_mac.sv
// Multiply-accumulate for the all-pole filter: signed y*a, arithmetic shift right by DW-1
// (floor), summed into a registered accumulator with clear and enable.
module iir_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 23
) (
  input  logic                    clk_i,
  input  logic                    srst_n_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DW-1:0]           y_i,
  input  logic [DW-1:0]           a_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  // Product, Q-shift and next accumulator value; clear wins over enable.
  always_comb begin
    prod  = $signed(y_i) * $signed(a_i);
    term  = ACC_W'(prod >>> (DW - 1));
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + term;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ram.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
module ram #(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter string       RAMSTYLE = "M9K"
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  (* ramstyle = RAMSTYLE *) logic [DW-1:0] mem [DEPTH];

  // Write when enabled; read is always registered.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/rom.sv
// Coefficient ROM with a registered (1-cycle) read.
// Contents come from INIT (word i at bits [i*DW +: DW]); FILE names the matching
// memory image handed to the vendor flow.
module rom #(
  parameter int unsigned           DW    = 16,
  parameter int unsigned           DEPTH = 32,
  parameter int unsigned           AW    = 5,
  parameter string                 FILE  = "none.mem",
  parameter logic [DEPTH*DW-1:0]   INIT  = '0
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] rdata_o
);

  // Registered lookup.
  always_ff @(posedge clk_i) begin
    rdata_o <= INIT[addr_i*DW +: DW];
  end

endmodule

// File: rtl/ram_iir_allpole.sv
// All-pole IIR: y[n] = x[n] - sum_{k=1..ORDER} a_k * y[n-k], one MAC per clock.
// Output history is a circular buffer in RAM, coefficients a_1..a_ORDER in ROM.
// Define IIR_SAT_EN to clamp the result instead of wrapping it.
module ram_iir_allpole
  import iir_pkg::*;
#(
  parameter int unsigned         DW          = 16,
  parameter int unsigned         ORDER       = 32,
  parameter string               COEFFS_FILE = "none.mem",
  parameter string               RAMSTYLE    = "M9K",
  parameter logic [ORDER*DW-1:0] COEFFS      = '0
) (
  input logic             clk_i,
  input logic             srst_n_i,
  ram_iir_allpole_if.slave bus_io
);

  localparam int unsigned   ACC_W    = acc_width(DW, ORDER);
  localparam int unsigned   YW       = ACC_W + 1;
  localparam int unsigned   AW       = $clog2(ORDER);
  localparam logic [AW-1:0] LastAddr = AW'(ORDER - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          rd_vld_q;

  logic          accept;
  logic          ready;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] hist_rdata;
  logic [DW-1:0] coef_rdata;

  logic signed [ACC_W-1:0] acc;
  logic signed [YW-1:0]    y_full;
  logic [DW-1:0]           y_nar;

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? LastAddr : p - AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LastAddr) ? '0 : p + AW'(1);
  endfunction

  assign accept = (state_q == IDLE_S) && bus_io.sample_valid_i;

  ram #(
    .DW       (DW),
    .DEPTH    (ORDER),
    .AW       (AW),
    .RAMSTYLE (RAMSTYLE)
  ) u_hist (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rptr_q),
    .rdata_o (hist_rdata)
  );

  rom #(
    .DW    (DW),
    .DEPTH (ORDER),
    .AW    (AW),
    .FILE  (COEFFS_FILE),
    .INIT  (COEFFS)
  ) u_coef (
    .clk_i   (clk_i),
    .addr_i  (cnt_q),
    .rdata_o (coef_rdata)
  );

  // Reads land one cycle after issue, so the MAC runs on the cycle after each RUN_S cycle.
  iir_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i    (clk_i),
    .srst_n_i (srst_n_i),
    .clr_i    (accept),
    .en_i     (rd_vld_q),
    .y_i      (hist_rdata),
    .a_i      (coef_rdata),
    .acc_o    (acc)
  );

  // Result: x minus feedback sum, narrowed to DW bits.
`ifdef IIR_SAT_EN
  always_comb begin
    y_full = YW'($signed(x_q)) - YW'(acc);
    y_nar  = DW'(sat_narrow(64'(y_full), DW));
  end
`else
  logic unused_y_hi;
  always_comb begin
    y_full      = YW'($signed(x_q)) - YW'(acc);
    y_nar       = y_full[DW-1:0];
    unused_y_hi = ^y_full[YW-1:DW];
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= CLEAR_S;
      cnt_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      x_q      <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      x_q      <= x_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      rd_vld_q <= (state_q == RUN_S);
    end
  end

  // Next-state and pointer sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    x_d     = x_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      CLEAR_S: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = IDLE_S;
        end
      end
      IDLE_S: begin
        if (bus_io.sample_valid_i) begin
          x_d     = bus_io.data_i;
          cnt_d   = '0;
          rptr_d  = ptr_dec(wptr_q);
          state_d = RUN_S;
        end
      end
      RUN_S: begin
        cnt_d  = cnt_q + AW'(1);
        rptr_d = ptr_dec(rptr_q);
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = LAST_S;
        end
      end
      LAST_S: begin
        state_d = WRITE_S;
      end
      WRITE_S: begin
        data_d  = y_nar;
        valid_d = 1'b1;
        wptr_d  = ptr_inc(wptr_q);
        state_d = IDLE_S;
      end
      default: begin
        cnt_d   = '0;
        state_d = CLEAR_S;
      end
    endcase
  end

  // History write port and handshake outputs.
  always_comb begin
    ready     = (state_q == IDLE_S);
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    ram_wdata = y_nar;
    case (state_q)
      CLEAR_S: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
      end
      WRITE_S: begin
        ram_we = 1'b1;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  assign bus_io.ready_o      = ready;
  assign bus_io.data_o       = data_q;
  assign bus_io.data_valid_o = valid_q;

endmodule

// File: tb/tb_ram_iir_allpole.sv
// Directed bench for ram_iir_allpole, ORDER=4, three instances with different coefficients:
// all zero, a_1 = -0.5 and a_1 = -1.0.
module tb_ram_iir_allpole;

  localparam int unsigned DW    = 16;
  localparam int unsigned ORDER = 4;

`ifdef IIR_SAT_EN
  localparam logic signed [DW-1:0] NEG1_Y1 = 16'sd32767;
  localparam logic signed [DW-1:0] NEG1_Y2 = 16'sd32767;
`else
  localparam logic signed [DW-1:0] NEG1_Y1 = -16'sd5536;
  localparam logic signed [DW-1:0] NEG1_Y2 = 16'sd24464;
`endif

  logic                  clk    = 1'b0;
  logic                  srst_n = 1'b0;
  logic [2:0]            sv;
  logic [2:0][DW-1:0]    din;
  wire  [2:0]            rdy;
  wire  [2:0]            dv;
  wire  [2:0][DW-1:0]    dout;

  int                    n_chk  = 0;
  int                    n_pass = 0;
  int                    pulses;
  int                    lat;
  logic signed [DW-1:0]  ycap;

  always #5 clk = ~clk;

  ram_iir_allpole_if #(.DW(DW)) if_z ();
  ram_iir_allpole_if #(.DW(DW)) if_h ();
  ram_iir_allpole_if #(.DW(DW)) if_n ();

  assign if_z.sample_valid_i = sv[0];
  assign if_z.data_i         = din[0];
  assign rdy[0]              = if_z.ready_o;
  assign dout[0]             = if_z.data_o;
  assign dv[0]               = if_z.data_valid_o;

  assign if_h.sample_valid_i = sv[1];
  assign if_h.data_i         = din[1];
  assign rdy[1]              = if_h.ready_o;
  assign dout[1]             = if_h.data_o;
  assign dv[1]               = if_h.data_valid_o;

  assign if_n.sample_valid_i = sv[2];
  assign if_n.data_i         = din[2];
  assign rdy[2]              = if_n.ready_o;
  assign dout[2]             = if_n.data_o;
  assign dv[2]               = if_n.data_valid_o;

  ram_iir_allpole #(
    .DW (DW), .ORDER (ORDER), .COEFFS_FILE ("none.mem"), .RAMSTYLE ("M9K"),
    .COEFFS (64'h0000_0000_0000_0000)
  ) u_zero (
    .clk_i (clk), .srst_n_i (srst_n), .bus_io (if_z)
  );

  ram_iir_allpole #(
    .DW (DW), .ORDER (ORDER), .COEFFS_FILE ("none.mem"), .RAMSTYLE ("M9K"),
    .COEFFS (64'h0000_0000_0000_C000)
  ) u_half (
    .clk_i (clk), .srst_n_i (srst_n), .bus_io (if_h)
  );

  ram_iir_allpole #(
    .DW (DW), .ORDER (ORDER), .COEFFS_FILE ("none.mem"), .RAMSTYLE ("M9K"),
    .COEFFS (64'h0000_0000_0000_8000)
  ) u_neg1 (
    .clk_i (clk), .srst_n_i (srst_n), .bus_io (if_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Hold reset two cycles, release, and watch the clear phase on instance 0.
  task automatic do_reset(input string tag);
    sv     = '0;
    srst_n = 1'b0;
    tick();
    tick();
    srst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check({tag, " ready low"}, 32'(rdy[0]), 0);
      check({tag, " no valid"}, 32'(dv[0]), 0);
      tick();
    end
    check({tag, " ready high"}, 32'(rdy[0]), 1);
    check({tag, " data_o zero"}, 32'(dout[0]), 0);
    check({tag, " half data_o zero"}, 32'(dout[1]), 0);
  endtask

  // One strobe; result expected at cycle 7, then the next strobe may come at cycle 8.
  task automatic sample(input int d, input logic signed [DW-1:0] x,
                        input logic signed [DW-1:0] exp, input string tag);
    int                   l;
    logic                 r;
    logic signed [DW-1:0] y;
    l      = -1;
    r      = 1'b0;
    y      = 'x;
    sv[d]  = 1'b1;
    din[d] = x;
    for (int c = 1; c <= 15 && l < 0; c++) begin
      tick();
      sv[d]  = 1'b0;
      din[d] = '0;
      if (dv[d]) begin
        l = c;
        y = dout[d];
        r = rdy[d];
      end
    end
    check({tag, " latency"}, l, 7);
    check({tag, " y"}, y, exp);
    check({tag, " ready at valid"}, 32'(r), 1);
    tick();
    check({tag, " pulse ends"}, 32'(dv[d]), 0);
  endtask

  initial begin
    sv  = '0;
    din = '0;

    do_reset("reset");
    check("reset half ready", 32'(rdy[1]), 1);
    check("reset neg1 data_o", 32'(dout[2]), 0);

    // Zero coefficients pass x straight through.
    sample(0, 16'sd1000, 16'sd1000, "zero 1000");

    // Second strobe in RUN_S is dropped.
    sv[0]  = 1'b1;
    din[0] = 16'd500;
    tick();
    sv[0] = 1'b0;
    check("busy ready", 32'(rdy[0]), 0);
    tick();
    sv[0]  = 1'b1;
    din[0] = 16'hFFF9;
    tick();
    sv[0] = 1'b0;
    pulses = 0;
    lat    = -1;
    ycap   = '0;
    for (int c = 3; c <= 20; c++) begin
      if (dv[0]) begin
        pulses++;
        if (lat < 0) begin
          lat  = c;
          ycap = dout[0];
        end
      end
      tick();
    end
    check("drop pulses", pulses, 1);
    check("drop latency", lat, 7);
    check("drop y", ycap, 500);

    // a_1 = -0.5: impulse response halves each sample.
    sample(1, 16'sd16384, 16'sd16384, "half y0");
    sample(1, 16'sd0, 16'sd8192, "half y1");
    sample(1, 16'sd0, 16'sd4096, "half y2");
    sample(1, 16'sd0, 16'sd2048, "half y3");
    sample(1, 16'sd0, 16'sd1024, "half y4");

    // a_1 = -1.0 with constant input overflows on the second output.
    sample(2, 16'sd30000, 16'sd30000, "neg1 y0");
    sample(2, 16'sd30000, NEG1_Y1, "neg1 y1");
    sample(2, 16'sd30000, NEG1_Y2, "neg1 y2");

    // Reset in RUN_S of the third impulse-response sample.
    do_reset("rst2");
    sample(1, 16'sd16384, 16'sd16384, "pre y0");
    sample(1, 16'sd0, 16'sd8192, "pre y1");
    sv[1]  = 1'b1;
    din[1] = '0;
    tick();
    sv[1] = 1'b0;
    tick();
    check("midrun busy", 32'(rdy[1]), 0);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (dv[1]) pulses++;
      tick();
    end
    check("abort pulses", pulses, 0);
    check("abort data_o", 32'(dout[1]), 0);
    check("abort ready", 32'(rdy[1]), 1);
    sample(1, 16'sd16384, 16'sd16384, "post y0");
    sample(1, 16'sd0, 16'sd8192, "post y1");
    sample(1, 16'sd0, 16'sd4096, "post y2");
    sample(1, 16'sd0, 16'sd2048, "post y3");

    // Small impulse: floor rounding of negative products gives a limit cycle at 1.
    do_reset("rst3");
    sample(1, 16'sd3, 16'sd3, "floor y0");
    sample(1, 16'sd0, 16'sd2, "floor y1");
    sample(1, 16'sd0, 16'sd1, "floor y2");
    sample(1, 16'sd0, 16'sd1, "floor y3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_iir_allpole.md
# ram_iir_allpole

All-pole (recursive) IIR filter, the synthesis-side inverse of the team's RAM-based FIR: y[n] = x[n] − Σ a_k·y[n−k] for k = 1..ORDER. Output history lives in a block-RAM circular buffer and coefficients in a block ROM. One multiply-accumulate runs per clock, so each input strobe takes ORDER+3 cycles. It sits in the audio path after FIR stages, or on its own as an LPC-style decoder.

## Interface
- DW, 16: sample and coefficient width, signed two's complement; coefficients Q1.(DW−1)
- ORDER, 32: number of feedback taps, ≥ 2, any integer
- COEFFS_FILE, "none.mem": ROM init; a_1..a_ORDER at addresses 0..ORDER−1
- RAMSTYLE, "M9K": forwarded to the history RAM
- clk_i  in  1  single clock; all logic is on its rising edge
- srst_n_i  in  1  synchronous reset, active-low
- sample_valid_i  in  1  one-cycle strobe; data_i is sampled on it
- data_i  in  DW  input sample x[n]; only needs to be valid with the strobe
- ready_o  out  1  high when a strobe will be accepted; reset value 0
- data_o  out  DW  last y[n], held between updates; reset value 0
- data_valid_o  out  1  one-cycle pulse when data_o updates; reset value 0

## Operation
- States:
  - CLEAR_S: entered on reset. Writes 0 to history addresses 0..ORDER−1, one per cycle, then goes to IDLE_S.
  - IDLE_S: ready_o = 1. A strobe latches data_i and the state goes to RUN_S.
  - RUN_S: ORDER cycles, issuing read k = 1..ORDER. History address is (wptr − k) mod ORDER, via a decrementing read pointer with explicit wrap. Coefficient address is k−1.
  - LAST_S: one cycle; accumulates the final product.
  - WRITE_S: computes y. Writes y to history[wptr]. Advances wptr with wrap at ORDER−1 → 0. Registers data_o. Goes to IDLE_S.
- RAM and ROM reads have 1-cycle latency, so the MAC trails address issue by one cycle. The accumulator is cleared on entry to RUN_S.
- Product: signed(y)·signed(a) is DW×DW → 2·DW bits, then arithmetic right shift by DW−1 (rounds toward −∞).
- Accumulator width ACC_W = DW + 2 + $clog2(ORDER). No overflow is possible inside the MAC.
- Result: y_full = sign-extended x − acc, computed in ACC_W+1 bits. It is narrowed to DW bits per the Configuration section.
- Strobes seen while ready_o = 0 (CLEAR_S, RUN_S, LAST_S, WRITE_S) are dropped silently. State and data_o are unaffected.
- Reset mid-operation:
  - state → CLEAR_S, wptr → 0, accumulator → 0.
  - data_o → 0, data_valid_o → 0. The in-flight sample is discarded.
  - History is fully re-zeroed before the next accepted sample.

## Timing
- Reset:
  - srst_n_i sampled low on cycle r.
  - CLEAR_S runs from the first cycle srst_n_i is high, for ORDER cycles.
  - ready_o rises ORDER cycles after reset release.
- Strobe accepted in cycle 0:
  - RUN_S in cycles 1..ORDER.
  - LAST_S in cycle ORDER+1.
  - WRITE_S in cycle ORDER+2.
- Cycle ORDER+3:
  - data_o holds the new y; data_valid_o = 1 for exactly this cycle.
  - ready_o = 1; a strobe in this cycle is accepted.
- Minimum sample period is ORDER+3 clocks.
- The history write in WRITE_S and the first read of the next sample never touch the same address in the same cycle.

## Configuration
- IIR_SAT_EN defined: y_full is clamped to [−2^(DW−1), 2^(DW−1)−1] before the history write and data_o.
- IIR_SAT_EN undefined: y is y_full[DW−1:0] (two's-complement wrap). This saves the comparators but allows limit cycles.
- The same narrowed value is both stored and output in either case.

## Structure
- Package iir_pkg holds:
  - state enum (CLEAR_S, IDLE_S, RUN_S, LAST_S, WRITE_S)
  - function acc_width(DW, ORDER)
  - function sat_narrow() for the IIR_SAT_EN path
- Reuse the existing ram (history, RAMSTYLE) and rom (coefficients, COEFFS_FILE) modules.
- The only new sub-module is iir_mac: registered product, shift and accumulate, with clear and enable inputs.

## Test plan
- Reset release, ORDER=4:
  - ready_o stays 0 for 4 cycles, then goes 1.
  - data_o = 0, and no data_valid_o pulse occurs.
- ORDER=4, all coefficients 0, strobe x=1000 at cycle 0:
  - data_valid_o at cycle 7, data_o = 1000.
- a_1 = 0xC000 (−0.5), others 0; impulse 16384 then zeros at period 8:
  - outputs are 16384, 8192, 4096, 2048, 1024.
- a_1 = 0x8000 (−1.0); constant x=30000:
  - outputs are 30000, then 32767 with IIR_SAT_EN.
  - without IIR_SAT_EN the second output is −5536 (wrap).
- Second strobe 2 cycles after the first:
  - exactly one data_valid_o pulse.
  - the result equals the single-strobe case.
- Reset asserted in RUN_S of the third impulse-response sample:
  - no pulse is emitted; data_o = 0.
  - after the re-clear, a new impulse reproduces 16384, 8192, … exactly.
